// File: rtl/divu_sequencer.sv
// Sequencer for an external unsigned divider: runs the DIVU opcode sequence,
// keeps the HI/LO result pair and answers DIVU/MFHI/MFLO over valid/ready.
module divu_sequencer #(
  parameter int unsigned DIV_CYCLES = 32'd34,
  parameter int unsigned OUT_WAIT   = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_dz,
  output logic [5:0]  div_signal,
  output logic [31:0] div_dataA,
  output logic [31:0] div_dataB,
  output logic        div_reset,
  input  logic [63:0] div_dataOut,
  output logic        busy
);

  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] SIG_OUT  = 6'b111111;
  localparam logic [5:0] SIG_NONE = 6'b000000;
  localparam logic [6:0] ITER_LAST = 7'(DIV_CYCLES - 32'd1);
  localparam logic [6:0] OUT_LAST  = 7'(OUT_WAIT - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ITER   = 3'd2,
    S_RESULT = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] rsp_data_q, rsp_data_d, div_a_q, div_a_d, div_b_q, div_b_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_dz_q, rsp_dz_d;
  logic        div_reset_q, div_reset_d, busy_q, busy_d;
  logic [5:0]  div_signal_q, div_signal_d;
  logic        accept_s;

  assign req_ready  = (state_q == S_IDLE);
  assign accept_s   = req_valid && (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_dz     = rsp_dz_q;
  assign div_signal = div_signal_q;
  assign div_dataA  = div_a_q;
  assign div_dataB  = div_b_q;
  assign div_reset  = div_reset_q;
  assign busy       = busy_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 7'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_err_q    <= 1'b0;
      rsp_dz_q     <= 1'b0;
      div_signal_q <= SIG_NONE;
      div_a_q      <= 32'd0;
      div_b_q      <= 32'd0;
      div_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_dz_q     <= rsp_dz_d;
      div_signal_q <= div_signal_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_reset_q  <= div_reset_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!accept_s) state_d = S_IDLE;
        else if (req_op == OP_DIVU && req_b != 32'd0) state_d = S_CLEAR;
        else state_d = S_RESP;
      end
      S_CLEAR:  state_d = S_ITER;
      S_ITER: begin
        if (cnt_q == ITER_LAST) state_d = S_RESULT;
        else state_d = S_ITER;
      end
      S_RESULT: begin
        if (cnt_q == OUT_LAST) state_d = S_RESP;
        else state_d = S_RESULT;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
        else state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath values; outputs are registered from the upcoming state.
  always_comb begin
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_dz_d    = rsp_dz_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    div_reset_d = (state_d == S_CLEAR);
    case (state_d)
      S_ITER:   div_signal_d = OP_DIVU;
      S_RESULT: div_signal_d = SIG_OUT;
      default:  div_signal_d = SIG_NONE;
    endcase
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          rsp_err_d = 1'b0;
          rsp_dz_d  = 1'b0;
          case (req_op)
            OP_DIVU: begin
              if (req_b != 32'd0) begin
                div_a_d = req_a;
                div_b_d = req_b;
              end else begin
                // Divide by zero never starts the divider; result is fixed.
                lo_d       = 32'hFFFF_FFFF;
                hi_d       = req_a;
                rsp_data_d = 32'hFFFF_FFFF;
                rsp_dz_d   = 1'b1;
              end
            end
            OP_MFHI: rsp_data_d = hi_q;
            OP_MFLO: rsp_data_d = lo_q;
            default: begin
              rsp_data_d = 32'd0;
              rsp_err_d  = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CLEAR: cnt_d = 7'd0;
      S_ITER: begin
        if (cnt_q == ITER_LAST) cnt_d = 7'd0;
        else cnt_d = cnt_q + 7'd1;
      end
      S_RESULT: begin
        if (cnt_q == OUT_LAST) begin
          cnt_d      = 7'd0;
          lo_d       = div_dataOut[63:32];
          hi_d       = div_dataOut[31:0];
          rsp_data_d = div_dataOut[63:32];
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          rsp_dz_d  = 1'b0;
        end else begin
          rsp_err_d = rsp_err_q;
          rsp_dz_d  = rsp_dz_q;
        end
      end
      default: cnt_d = 7'd0;
    endcase
  end

endmodule

// File: tb/tb_divu_sequencer.sv
// Directed bench for divu_sequencer with a behavioural divider that presents
// {quotient, remainder} while the divider opcode is OUT.
module tb_divu_sequencer;

  localparam logic [5:0] OP_DIVU = 6'b011011;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] SIG_OUT = 6'b111111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [5:0]  req_op = 6'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err, rsp_dz;
  logic [5:0]  div_signal;
  logic [31:0] div_dataA, div_dataB;
  logic        div_reset;
  logic [63:0] div_dataOut;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat;
  int n_divu, n_out, n_rst, rst_at, divu_first, n_nz, n_rdy, n_unstable;

  divu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_dz(rsp_dz),
    .div_signal(div_signal), .div_dataA(div_dataA), .div_dataB(div_dataB),
    .div_reset(div_reset), .div_dataOut(div_dataOut), .busy(busy)
  );

  always #5 clk = ~clk;

  assign div_dataOut = (div_signal == SIG_OUT && div_dataB != 32'd0) ?
                       {div_dataA / div_dataB, div_dataA % div_dataB} : 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && n < 200) begin
      step();
      n = n + 1;
    end
    chk("accept_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge; lat=1 means response in cycle T0+1.
  task automatic wait_rsp(output int l);
    l = 1;
    n_divu = 0; n_out = 0; n_rst = 0; rst_at = 0; divu_first = 0; n_nz = 0; n_rdy = 0;
    while (!rsp_valid && l < 200) begin
      if (div_signal == OP_DIVU) begin
        n_divu = n_divu + 1;
        if (divu_first == 0) divu_first = l;
      end
      if (div_signal == SIG_OUT) n_out = n_out + 1;
      if (div_signal != 6'd0) n_nz = n_nz + 1;
      if (div_reset) begin
        n_rst = n_rst + 1;
        rst_at = l;
      end
      if (req_ready) n_rdy = n_rdy + 1;
      step();
      l = l + 1;
    end
    chk("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic consume();
    step();
    chk("rsp_cleared", {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic read_reg(input logic [5:0] op, input logic [31:0] exp, input string tag);
    send(op, 32'd0, 32'd0);
    wait_rsp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd1);
    chk({tag, "_data"}, {32'd0, rsp_data}, {32'd0, exp});
    consume();
  endtask

  initial begin
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_div_reset", {63'd0, div_reset}, 64'd1);
    chk("rst_outs", {div_signal, div_dataA, rsp_data, rsp_err, rsp_dz},
        {6'd0, 32'd0, 32'd0, 1'b0, 1'b0});
    reset = 1'b1;
    step();
    chk("idle_ready", {63'd0, req_ready}, 64'd1);
    chk("idle_div_reset", {63'd0, div_reset}, 64'd0);

    // 100 / 7 = 14 rem 2
    send(OP_DIVU, 32'd100, 32'd7);
    wait_rsp(lat);
    chk("d1_lat", 64'(lat), 64'd37);
    chk("d1_data", {32'd0, rsp_data}, 64'd14);
    chk("d1_flags", {62'd0, rsp_err, rsp_dz}, 64'd0);
    consume();
    read_reg(OP_MFHI, 32'd2, "d1_hi");
    read_reg(OP_MFLO, 32'd14, "d1_lo");

    // FFFFFFFF / 1, operands changed on the request bus while busy
    send(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    req_a = 32'h1234_5678; req_b = 32'd0;
    wait_rsp(lat);
    chk("d2_lat", 64'(lat), 64'd37);
    chk("d2_data", {32'd0, rsp_data}, 64'h0000_0000_FFFF_FFFF);
    chk("d2_n_divu", 64'(n_divu), 64'd34);
    chk("d2_n_out", 64'(n_out), 64'd1);
    chk("d2_n_rst", 64'(n_rst), 64'd1);
    chk("d2_rst_before_iter", 64'(divu_first), 64'(rst_at + 1));
    chk("d2_operands", {div_dataA, div_dataB}, {32'hFFFF_FFFF, 32'd1});
    consume();
    read_reg(OP_MFHI, 32'd0, "d2_hi");

    // 55 / 0
    send(OP_DIVU, 32'd55, 32'd0);
    wait_rsp(lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_data", {32'd0, rsp_data}, 64'h0000_0000_FFFF_FFFF);
    chk("dz_flags", {62'd0, rsp_err, rsp_dz}, 64'd1);
    chk("dz_sig", {58'd0, div_signal}, 64'd0);
    consume();
    chk("dz_flag_clear", {63'd0, rsp_dz}, 64'd0);
    read_reg(OP_MFHI, 32'd55, "dz_hi");
    read_reg(OP_MFLO, 32'hFFFF_FFFF, "dz_lo");

    // 9 / 3 with MFLO queued behind it and a stalled response
    rsp_ready = 1'b0;
    send(OP_DIVU, 32'd9, 32'd3);
    req_valid = 1'b1; req_op = OP_MFLO;
    wait_rsp(lat);
    chk("d4_lat", 64'(lat), 64'd37);
    chk("d4_ready_while_busy", 64'(n_rdy), 64'd0);
    n_unstable = 0;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || rsp_data != 32'd3 || req_ready) n_unstable = n_unstable + 1;
      step();
    end
    chk("d4_stall_stable", 64'(n_unstable), 64'd0);
    chk("d4_data", {32'd0, rsp_data}, 64'd3);
    rsp_ready = 1'b1;
    step();
    chk("d4_consumed", {62'd0, rsp_valid, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    chk("d4_mflo", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'd3});
    consume();

    // illegal opcode leaves HI/LO untouched
    send(6'b000001, 32'd77, 32'd5);
    wait_rsp(lat);
    chk("ill_lat", 64'(lat), 64'd1);
    chk("ill_rsp", {30'd0, rsp_err, rsp_dz, rsp_data}, {30'd0, 1'b1, 1'b0, 32'd0});
    consume();
    read_reg(OP_MFLO, 32'd3, "ill_lo");

    // reset in the middle of ITER
    send(OP_DIVU, 32'd50, 32'd7);
    for (int i = 0; i < 9; i++) step();
    chk("ab_mid_iter", {63'd0, div_signal == OP_DIVU}, 64'd1);
    reset = 1'b0;
    #1;
    chk("ab_state", {busy, rsp_valid, div_reset}, {1'b0, 1'b0, 1'b1});
    step();
    step();
    chk("ab_held", {busy, rsp_valid, div_reset, div_signal}, {1'b0, 1'b0, 1'b1, 6'd0});
    reset = 1'b1;
    step();
    chk("ab_no_rsp", {63'd0, rsp_valid}, 64'd0);
    read_reg(OP_MFHI, 32'd0, "ab_hi");
    read_reg(OP_MFLO, 32'd0, "ab_lo");
    send(OP_DIVU, 32'd20, 32'd4);
    wait_rsp(lat);
    chk("ab_d_lat", 64'(lat), 64'd37);
    chk("ab_d_data", {32'd0, rsp_data}, 64'd5);
    consume();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/divu_sequencer.md
Name: divu_sequencer

Overview:
- Multi-cycle controller that owns the unsigned divider datapath and a HI/LO result register pair.
- Accepts DIVU, MFHI and MFLO requests from the ALU issue stage over a valid/ready handshake.
- For DIVU it drives the divider's 6-bit Signal opcode sequence, operands and reset, then captures the 64-bit result into HI/LO and returns one response per request.
- Stalls HI/LO reads while a division is in flight.

Parameters:
- DIV_CYCLES, 34, cycles the divider opcode is held at DIVU (6'b011011) before result read-out.
- OUT_WAIT, 1, cycles the divider opcode is held at OUT (6'b111111) before capture.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  6  request opcode: DIVU 6'b011011, MFHI 6'b010000, MFLO 6'b010010.
- req_a  in  32  dividend.
- req_b  in  32  divisor.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  DIVU: quotient; MFHI: HI; MFLO: LO; illegal op: 0.
- rsp_err  out  1  illegal opcode.
- rsp_dz  out  1  DIVU with divisor zero.
- div_signal  out  6  opcode to divider.
- div_dataA  out  32  dividend to divider.
- div_dataB  out  32  divisor to divider.
- div_reset  out  1  active-high divider reset.
- div_dataOut  in  64  divider result: [63:32] quotient, [31:0] remainder.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, reset low): state IDLE, HI=0, LO=0, counter=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_dz=0, div_signal=6'b000000, div_dataA=0, div_dataB=0, div_reset=1, busy=0.
- Handshake:
  - Accept occurs on an edge where req_valid && req_ready.
  - Response is held stable while rsp_valid && !rsp_ready.
  - Exactly one response is produced per accepted request.
- States: IDLE, CLEAR, ITER, RESULT, RESP.
- IDLE:
  - div_reset=0, div_signal=0.
  - On accepting DIVU with req_b!=0: latch req_a/req_b onto div_dataA/div_dataB, go to CLEAR.
  - On accepting DIVU with req_b==0:
    - The divider is not started.
    - Write LO=32'hFFFFFFFF and HI=req_a.
    - Go to RESP with rsp_data=32'hFFFFFFFF, rsp_dz=1.
  - On accepting MFHI/MFLO: go to RESP with rsp_data=HI/LO.
  - On accepting any other opcode: go to RESP with rsp_data=0, rsp_err=1.
- CLEAR: div_reset=1 for exactly 1 cycle, counter cleared, then go to ITER.
- ITER: div_signal=DIVU; counter increments each cycle; after DIV_CYCLES cycles go to RESULT with counter cleared.
- RESULT:
  - div_signal=OUT.
  - On the edge ending the OUT_WAIT-th cycle: LO<=div_dataOut[63:32], HI<=div_dataOut[31:0], rsp_data<=div_dataOut[63:32], go to RESP.
- RESP:
  - rsp_valid=1, div_signal=0.
  - On rsp_ready: clear rsp_valid/rsp_err/rsp_dz and go to IDLE.
  - No new request is accepted in the same cycle; the next accept is at the earliest 1 cycle after the response is consumed.
- Latency, acceptance edge = T0:
  - Nonzero DIVU: rsp_valid first high in cycle T0+2+DIV_CYCLES+OUT_WAIT, i.e. 37 cycles with defaults.
  - Divide-by-zero, MFHI, MFLO, illegal opcode: rsp_valid high in cycle T0+1.
- Operand stability: div_dataA/div_dataB stay constant from CLEAR through RESULT; changes on req_a/req_b in that window are ignored.
- HI/LO are written only at DIVU capture or the divide-by-zero write, never by MFHI/MFLO.
- Counter is 7 bits; DIV_CYCLES and OUT_WAIT must be at most 127.
- Reset asserted mid-operation:
  - All state returns to reset values immediately, and HI/LO are cleared.
  - No response is issued for the aborted request.
  - div_reset is held high while reset is low.

Test Plan:
- DIVU a=100, b=7, rsp_ready=1 -> rsp_valid at T0+37, rsp_data=14, then MFHI -> 2, MFLO -> 14, each responding at T0+1.
- DIVU a=32'hFFFFFFFF, b=1 -> quotient 32'hFFFFFFFF, HI=0; div_signal is DIVU for exactly 34 cycles then OUT for 1 cycle; div_reset is high exactly 1 cycle before ITER.
- DIVU a=55, b=0 -> rsp_valid at T0+1, rsp_data=32'hFFFFFFFF, rsp_dz=1; MFHI -> 55; div_signal stays 0 throughout.
- MFLO issued while busy from DIVU 9/3 -> req_ready=0 until RESP completes; MFLO then returns 3. Hold rsp_ready=0 for 5 cycles -> rsp_data and rsp_valid stay stable.
- Illegal op 6'b000001 -> rsp_valid at T0+1, rsp_err=1, rsp_data=0, HI/LO unchanged.
- reset low during ITER (cycle T0+10) -> busy=0, HI=LO=0, div_reset=1, no rsp_valid; a new DIVU 20/4 after release returns 5.
